// File: rtl/pipe_stage_reg_pkg.sv
// Shared handshake types for MINAv2 inter-stage pipeline registers.
package pipe_stage_reg_pkg;

  typedef struct packed {
    logic valid;
    logic ready;
  } pipe_hs_t;

  localparam int PIPE_SKID_DEPTH = 2;

  function automatic logic hs_xfer(input pipe_hs_t hs);
    return hs.valid & hs.ready;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating event counter: holds at all-ones instead of wrapping; clr wins over inc.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr)                         r_count <= '0;
    else if (inc && (r_count != '1)) r_count <= r_count + 1'b1;
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with a main slot plus one skid slot (FIFO depth 2).
// Optional perf counters (stall/flush) when MINA_PIPE_PERF_EN is defined.
import pipe_stage_reg_pkg::*;

module pipe_stage_reg #(
  parameter int               WIDTH  = 64,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush
`ifdef MINA_PIPE_PERF_EN
  ,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
`endif
);

  logic             r_main_vld;
  logic [WIDTH-1:0] r_main_data;
  logic             r_skid_vld;
  logic [WIDTH-1:0] r_skid_data;

  pipe_hs_t w_up_hs;
  pipe_hs_t w_dn_hs;
  logic     w_up_xfer;
  logic     w_dn_xfer;

  // in_ready comes straight from a flop: no combinational path from out_ready.
  assign in_ready  = ~r_skid_vld;
  assign out_valid = r_main_vld;
  assign out_data  = r_main_data;

  assign w_up_hs   = '{valid: in_valid,   ready: in_ready};
  assign w_dn_hs   = '{valid: r_main_vld, ready: out_ready};
  assign w_up_xfer = hs_xfer(w_up_hs);
  assign w_dn_xfer = hs_xfer(w_dn_hs);

  // r_main_data is kept at BUBBLE whenever the slot is empty, so out_data never shows stale beats.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      r_main_vld  <= 1'b0;
      r_main_data <= BUBBLE;
      r_skid_vld  <= 1'b0;
      r_skid_data <= BUBBLE;
    end else if (r_skid_vld) begin
      if (out_ready) begin
        r_main_vld  <= 1'b1;
        r_main_data <= r_skid_data;
        r_skid_vld  <= 1'b0;
        r_skid_data <= BUBBLE;
      end
    end else if (!r_main_vld || w_dn_xfer) begin
      r_main_vld  <= w_up_xfer;
      r_main_data <= w_up_xfer ? in_data : BUBBLE;
    end else if (w_up_xfer) begin
      r_skid_vld  <= 1'b1;
      r_skid_data <= in_data;
    end
  end

`ifdef MINA_PIPE_PERF_EN
  logic w_stall_inc;
  logic w_flush_inc;

  assign w_stall_inc = r_main_vld & ~out_ready;
  assign w_flush_inc = flush & (r_main_vld | r_skid_vld);

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr   (~rst_n),
    .inc   (w_stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr   (~rst_n),
    .inc   (w_flush_inc),
    .count (flush_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand sequences, and a random run
// against a depth-2 FIFO reference model.
module tb_pipe_stage_reg;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, out_ready, flush;
  logic [W-1:0] in_data;
  logic         in_ready, out_valid;
  logic [W-1:0] out_data;
`ifdef MINA_PIPE_PERF_EN
  logic [15:0]  stall_cnt, flush_cnt;
  logic         in_ready2, out_valid2;
  logic [W-1:0] out_data2;
  logic [1:0]   stall_cnt2, flush_cnt2;
`endif

  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(W), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush)
`ifdef MINA_PIPE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

`ifdef MINA_PIPE_PERF_EN
  pipe_stage_reg #(.WIDTH(W), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2), .in_data(in_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2), .flush(flush),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );
`endif

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: the stage is a 2-deep FIFO; in_ready means "fewer than two held".
  logic [W-1:0] mq[$];
  int m_stall, m_flush, m_stall2, m_flush2;

  task automatic model_step(input logic rn, iv, input logic [W-1:0] id, input logic ordy, fl);
    if (!rn) begin
      mq.delete();
      m_stall = 0; m_flush = 0; m_stall2 = 0; m_flush2 = 0;
    end else begin
      if (mq.size() > 0 && !ordy) begin
        m_stall++;
        if (m_stall2 < 3) m_stall2++;
      end
      if (fl && mq.size() > 0) begin
        m_flush++;
        if (m_flush2 < 3) m_flush2++;
      end
      if (fl) mq.delete();
      else begin
        bit up;
        up = iv && (mq.size() < 2);
        if (mq.size() > 0 && ordy) void'(mq.pop_front());
        if (up) mq.push_back(id);
      end
    end
  endtask

  task automatic cycle(input logic rn, iv, input logic [W-1:0] id, input logic ordy, fl);
    @(negedge clk);
    rst_n = rn; in_valid = iv; in_data = id; out_ready = ordy; flush = fl;
    @(posedge clk);
    model_step(rn, iv, id, ordy, fl);
    #1;
  endtask

  task automatic chk_model(input string tag);
    chk({tag, ".out_valid"}, W'(out_valid), W'(mq.size() > 0));
    chk({tag, ".out_data"},  out_data, (mq.size() > 0) ? mq[0] : '0);
    chk({tag, ".in_ready"},  W'(in_ready), W'(mq.size() < 2));
  endtask

  typedef struct {
    logic rn, iv; logic [W-1:0] id; logic ordy, fl;
    logic ev; logic [W-1:0] ed; logic er;
    bit cc; int es, ef;
  } vec_t;
  vec_t tv[$];

  task automatic add(input logic rn, iv, input logic [W-1:0] id, input logic ordy, fl,
                     input logic ev, input logic [W-1:0] ed, input logic er,
                     input bit cc = 0, input int es = 0, input int ef = 0);
    vec_t v;
    v = '{rn:rn, iv:iv, id:id, ordy:ordy, fl:fl, ev:ev, ed:ed, er:er, cc:cc, es:es, ef:ef};
    tv.push_back(v);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;

    // Reset with a beat offered
    add(0, 1, 64'hDEAD, 1, 0,  0, 0, 1);
    add(0, 1, 64'hDEAD, 1, 0,  0, 0, 1, 1, 0, 0);
    // Streaming 1..8
    for (int k = 1; k <= 8; k++) add(1, 1, k, 1, 0,  1, k, 1);
    add(1, 0, 0, 1, 0,  0, 0, 1);
    // Backpressure at beat 2 for three cycles
    add(1, 1, 1, 1, 0,  1, 1, 1);
    add(1, 1, 2, 1, 0,  1, 2, 1);
    add(1, 1, 3, 0, 0,  1, 2, 0);
    add(1, 1, 4, 0, 0,  1, 2, 0);
    add(1, 1, 4, 0, 0,  1, 2, 0);
    add(1, 1, 4, 1, 0,  1, 3, 1);
    add(1, 1, 4, 1, 0,  1, 4, 1);
    add(1, 1, 5, 1, 0,  1, 5, 1);
    add(1, 1, 6, 1, 0,  1, 6, 1);
    add(1, 0, 0, 1, 0,  0, 0, 1, 1, 3, 0);
    // Flush with both slots full, beat 7 offered in the flush cycle
    add(1, 1, 5, 1, 0,  1, 5, 1);
    add(1, 1, 6, 0, 0,  1, 5, 0);
    add(1, 1, 7, 0, 1,  0, 0, 1, 1, 5, 1);
    add(1, 0, 7, 1, 0,  0, 0, 1);
    // Flush with the stage empty
    add(1, 0, 0, 1, 1,  0, 0, 1, 1, 5, 1);
    // Reset while skid is full, then beat 9
    add(1, 1, 1, 0, 0,  1, 1, 1);
    add(1, 1, 2, 0, 0,  1, 1, 0);
    add(0, 1, 3, 0, 0,  0, 0, 1, 1, 0, 0);
    add(1, 1, 9, 1, 0,  1, 9, 1);
    add(1, 0, 0, 1, 0,  0, 0, 1);

    foreach (tv[i]) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(tv[i].rn, tv[i].iv, tv[i].id, tv[i].ordy, tv[i].fl);
      chk({t, ".out_valid"}, W'(out_valid), W'(tv[i].ev));
      chk({t, ".out_data"},  out_data, tv[i].ed);
      chk({t, ".in_ready"},  W'(in_ready), W'(tv[i].er));
`ifdef MINA_PIPE_PERF_EN
      if (tv[i].cc) begin
        chk({t, ".stall_cnt"}, W'(stall_cnt), W'(tv[i].es));
        chk({t, ".flush_cnt"}, W'(flush_cnt), W'(tv[i].ef));
      end
`endif
    end

    // Five flushes over live data; the 2-bit counter must stick at 3
    cycle(0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cycle(1, 1, 64'h100 + k, 0, 0);
      chk("satseq.load", out_data, 64'h100 + k);
      cycle(1, 0, 0, 0, 1);
      chk("satseq.flushed", W'(out_valid), 0);
    end
`ifdef MINA_PIPE_PERF_EN
    chk("satseq.flush_cnt", W'(flush_cnt), 5);
    chk("satseq.flush_cnt2", W'(flush_cnt2), 3);
    chk("satseq.stall_cnt2", W'(stall_cnt2), 3);
`endif

    // Random traffic against the model; beats carry a unique tag
    begin
      logic [W-1:0] tag;
      tag = 64'h1000;
      for (int c = 0; c < 10000; c++) begin
        logic rn, iv, ordy, fl;
        logic [W-1:0] id;
        rn   = ($urandom_range(0, 199) != 0);
        iv   = ($urandom_range(0, 3) != 0);
        ordy = ($urandom_range(0, 4) > 1);
        fl   = ($urandom_range(0, 39) == 0);
        id   = iv ? tag : {$urandom, $urandom};
        if (iv && in_ready) tag++;
        cycle(rn, iv, id, ordy, fl);
        chk_model("rand");
      end
`ifdef MINA_PIPE_PERF_EN
      chk("rand.stall_cnt",  W'(stall_cnt),  W'(m_stall));
      chk("rand.flush_cnt",  W'(flush_cnt),  W'(m_flush));
      chk("rand.stall_cnt2", W'(stall_cnt2), W'(m_stall2));
      chk("rand.flush_cnt2", W'(flush_cnt2), W'(m_flush2));
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
